// File: rtl/sb_eject_redirect_pkg.sv
// Shared MinBD router constants and types for the side-buffer eject/redirect stage.
package minbd_pkg;

    localparam int NUM_CH         = 4;
    localparam int FLIT_W         = 11;
    localparam int SB_DEPTH       = 6;
    localparam int FLIT_VALID_BIT = FLIT_W - 1;

    localparam logic [3:0] SB_FULL_COUNT = 4'(SB_DEPTH);

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_WAIT,
        SB_FORCE
    } sb_state_t;

endpackage

// File: rtl/sb_eject_redirect_if.sv
// Channel and side-buffer signals of the eject/redirect stage.
// The master side drives flits and the buffer head; the slave side is the stage itself.
interface sb_eject_redirect_if;
    import minbd_pkg::*;

    logic [NUM_CH*FLIT_W-1:0] in_flits;
    logic [NUM_CH-1:0]        in_defl;
    flit_t                    sb_head;
    logic [NUM_CH*FLIT_W-1:0] out_flits;
    flit_t                    sb_wr_flit;
    logic                     sb_wr_en;
    logic                     sb_inject;
    logic [3:0]               sb_count;

    modport master (
        output in_flits, in_defl, sb_head,
        input  out_flits, sb_wr_flit, sb_wr_en, sb_inject, sb_count
    );

    modport slave (
        input  in_flits, in_defl, sb_head,
        output out_flits, sb_wr_flit, sb_wr_en, sb_inject, sb_count
    );

endinterface

// File: rtl/sb_eject_redirect_rr_pick4.sv
// Round-robin picker over four requesters: grants the first request at or after start_i.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    logic [1:0] idx;

    always_comb begin
        grant_o = start_i;
        valid_o = 1'b0;
        idx     = start_i;
        // Walk from the farthest offset back so the nearest request is the one kept.
        for (int k = 3; k >= 0; k--) begin
            idx = start_i + 2'(k);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_eject_redirect.sv
// Eject/redirect stage ahead of the MinBD side buffer.
// Define SB_FORCE_REDIRECT_EN to add starvation tracking and forced head/flit swaps.
module sb_eject_redirect
    import minbd_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sb_eject_redirect_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must lie in 1..255");
    end

    flit_t             in_ch [NUM_CH];
    flit_t             out_d [NUM_CH];
    flit_t             out_q [NUM_CH];
    logic [NUM_CH-1:0] cand;
    logic [1:0]        pick;
    logic              pick_vld;
    logic              eject;
    logic              have_free;
    logic [1:0]        free_idx;
    logic              wr_en_d, wr_en_q;
    logic              inj_d, inj_q;
    flit_t             wr_flit_d, wr_flit_q;
    logic [3:0]        count_d, count_q;
    logic [1:0]        rr_d, rr_q;
    sb_state_t         state_d, state_q;

`ifdef SB_FORCE_REDIRECT_EN
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0] starve_d, starve_q;
    logic [1:0] red_d, red_q;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ch[c] = bus.in_flits[c*FLIT_W +: FLIT_W];
            if (!in_ch[c][FLIT_VALID_BIT]) in_ch[c] = '0;
            cand[c] = in_ch[c][FLIT_VALID_BIT] & bus.in_defl[c];
        end
    end

    rr_pick4 u_eject_pick (
        .req_i   (cand),
        .start_i (rr_q),
        .grant_o (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        out_d     = in_ch;
        wr_en_d   = 1'b0;
        wr_flit_d = '0;
        inj_d     = 1'b0;
        rr_d      = rr_q;
        have_free = 1'b0;
        free_idx  = 2'd0;
`ifdef SB_FORCE_REDIRECT_EN
        red_d     = red_q;
        eject     = pick_vld && (count_q < SB_FULL_COUNT) && (state_q != SB_FORCE);
`else
        eject     = pick_vld && (count_q < SB_FULL_COUNT);
`endif

        if (eject) begin
            wr_en_d     = 1'b1;
            wr_flit_d   = in_ch[pick];
            out_d[pick] = '0;
            rr_d        = pick + 2'd1;
        end

        // The slot just vacated by the eject counts as free for the head.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!out_d[c][FLIT_VALID_BIT]) begin
                have_free = 1'b1;
                free_idx  = 2'(c);
            end
        end

        if (state_q != SB_IDLE && have_free) begin
            out_d[free_idx] = bus.sb_head;
            inj_d           = 1'b1;
        end
`ifdef SB_FORCE_REDIRECT_EN
        else if (state_q == SB_FORCE) begin
            wr_en_d      = 1'b1;
            wr_flit_d    = in_ch[red_q];
            out_d[red_q] = bus.sb_head;
            inj_d        = 1'b1;
            red_d        = red_q + 2'd1;
        end
`endif

        count_d = count_q;
        if (wr_en_d && !inj_d)      count_d = count_q + 4'd1;
        else if (!wr_en_d && inj_d) count_d = count_q - 4'd1;

`ifdef SB_FORCE_REDIRECT_EN
        starve_d = starve_q;
        if (state_q == SB_IDLE || inj_d)  starve_d = '0;
        else if (starve_q != STARVE_MAX)  starve_d = starve_q + 8'd1;

        if (count_d == 4'd0)              state_d = SB_IDLE;
        else if (starve_d == STARVE_MAX)  state_d = SB_FORCE;
        else                              state_d = SB_WAIT;
`else
        state_d = (count_d == 4'd0) ? SB_IDLE : SB_WAIT;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '{default: '0};
            wr_en_q   <= 1'b0;
            inj_q     <= 1'b0;
            wr_flit_q <= '0;
            count_q   <= '0;
            rr_q      <= '0;
            state_q   <= SB_IDLE;
`ifdef SB_FORCE_REDIRECT_EN
            starve_q  <= '0;
            red_q     <= '0;
`endif
        end else begin
            out_q     <= out_d;
            wr_en_q   <= wr_en_d;
            inj_q     <= inj_d;
            wr_flit_q <= wr_flit_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            state_q   <= state_d;
`ifdef SB_FORCE_REDIRECT_EN
            starve_q  <= starve_d;
            red_q     <= red_d;
`endif
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign bus.out_flits[c*FLIT_W +: FLIT_W] = out_q[c];
    end

    assign bus.sb_wr_flit = wr_flit_q;
    assign bus.sb_wr_en   = wr_en_q;
    assign bus.sb_inject  = inj_q;
    assign bus.sb_count   = count_q;

endmodule
